// File: rtl/xbox_tcm_responder.sv
// xbox_tcm_responder: TCM banks serving an XLR line port (priority) and a SOC word port with write trigger and stall count
// Ports: clk/rst_n (async, active low); xlr_mem_* per-bank 256-bit line access (read latency 1);
// soc_req/we/addr/wdata -> soc_ready, soc_rvalid/soc_rdata; trig_soc_xmem_wr(_addr) after each SOC write;
// collision_cnt counts SOC stall cycles (saturating).
module xbox_tcm_responder #(
  parameter int NUM_MEMS = 2,
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int SPACE_SIZE_PER_MEM = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
  input  logic [NUM_MEMS-1:0][7:0][31:0] xlr_mem_wdata,
  input  logic [NUM_MEMS-1:0][31:0] xlr_mem_be,
  input  logic [NUM_MEMS-1:0] xlr_mem_rd,
  input  logic [NUM_MEMS-1:0] xlr_mem_wr,
  output logic [NUM_MEMS-1:0][7:0][31:0] xlr_mem_rdata,
  input  logic soc_req,
  input  logic soc_we,
  input  logic [18:0] soc_addr,
  input  logic [31:0] soc_wdata,
  output logic soc_ready,
  output logic soc_rvalid,
  output logic [31:0] soc_rdata,
  output logic trig_soc_xmem_wr,
  output logic [18:0] trig_soc_xmem_wr_addr,
  output logic [15:0] collision_cnt
);
  localparam int LINES = 2 ** LOG2_LINES_PER_MEM;
  localparam int LW = $clog2(SPACE_SIZE_PER_MEM);
  localparam int BW = 14 - LW;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  logic [0:0] state;
  logic [NUM_MEMS-1:0][LINES-1:0][255:0] mem;
  logic [BW-1:0] bank;
  logic [LW-1:0] line;
  logic [2:0] word;
  logic [LOG2_LINES_PER_MEM-1:0] ln;
  logic in_range, conflict, arb, soc_wr_ok;
  logic [31:0] soc_word;
  assign bank = soc_addr[18:5+LW];
  assign line = soc_addr[4+LW:5];
  assign word = soc_addr[4:2];
  assign ln = line[LOG2_LINES_PER_MEM-1:0];
  assign in_range = int'(bank) < NUM_MEMS && (line >> LOG2_LINES_PER_MEM) == '0;
  assign arb = state == IDLE && soc_req;
  assign soc_ready = arb && !conflict;
  assign soc_wr_ok = soc_ready && soc_we && in_range;
  // out-of-range requests never match a bank, so they never stall and read back 0
  always_comb begin
    conflict = 1'b0;
    soc_word = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (in_range && int'(bank) == m) begin
        conflict = xlr_mem_rd[m] | xlr_mem_wr[m];
        soc_word = mem[m][ln][{word, 5'b0} +: 32];
      end
    end
  end
  // a SOC write only commits when its bank has no XLR access, so the two writers never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
      xlr_mem_rdata <= '0;
    end else begin
      for (int m = 0; m < NUM_MEMS; m++) begin
        if (xlr_mem_rd[m]) xlr_mem_rdata[m] <= mem[m][xlr_mem_addr[m]];
        if (xlr_mem_wr[m])
          for (int k = 0; k < 32; k++)
            if (xlr_mem_be[m][k]) mem[m][xlr_mem_addr[m]][8*k +: 8] <= xlr_mem_wdata[m][k/4][8*(k%4) +: 8];
        if (soc_wr_ok && int'(bank) == m) mem[m][ln][{word, 5'b0} +: 32] <= soc_wdata;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      soc_rvalid <= 1'b0;
      soc_rdata <= '0;
      trig_soc_xmem_wr <= 1'b0;
      trig_soc_xmem_wr_addr <= '0;
      collision_cnt <= '0;
    end else begin
      state <= (soc_ready && !soc_we) ? RESP : IDLE;
      soc_rvalid <= soc_ready && !soc_we;
      if (soc_ready && !soc_we) soc_rdata <= soc_word;
      trig_soc_xmem_wr <= soc_ready && soc_we;
      if (soc_ready && soc_we) trig_soc_xmem_wr_addr <= soc_addr;
      if (arb && conflict && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
    end
  end
endmodule
